// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to active-low segment decoder with a blank override.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  assign pattern = blank ? SEG_OFF : HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 4-digit seven-segment driver with anti-ghost blanking,
// frame-synchronous double buffering and optional leading-zero blanking.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  in_clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  scan_state_e state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [IW-1:0] idx, idx_next;
  logic frame_boundary;

  logic [4*DIGITS-1:0] shadow, display;
  logic [DIGITS-1:0]   shadow_dp, display_dp;

  logic [DIGITS-1:0] lz_mask;
  logic              zero_run;
  logic [3:0]        cur_nibble;
  logic              cur_blank;
  logic [6:0]        cur_pattern;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;
  logic              dp_next;

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt + CW'(1);
    idx_next       = idx;
    frame_boundary = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) state_next = DRIVE;
      end
      DRIVE: begin
        if (cnt == SLOT_LAST) begin
          state_next     = BLANK;
          cnt_next       = '0;
          idx_next       = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          frame_boundary = (idx == IDX_LAST);
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // A load on the frame edge lands in the shadow after the commit has taken the old contents.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      shadow     <= '0;
      shadow_dp  <= '0;
      display    <= '0;
      display_dp <= '0;
      pending    <= 1'b0;
    end else begin
      if (frame_boundary && pending) begin
        display    <= shadow;
        display_dp <= shadow_dp;
      end
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end else if (frame_boundary) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    lz_mask  = '0;
    zero_run = lz_blank;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (display[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  assign cur_nibble = display[4*idx_next +: 4];
  assign cur_blank  = (state_next == BLANK) || lz_mask[idx_next];

  seg7_hex_decode u_decode (
    .nibble  (cur_nibble),
    .blank   (cur_blank),
    .pattern (cur_pattern)
  );

  // Outputs are computed from the next state so they switch on the entering edge.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (state_next == DRIVE) begin
      an_next[idx_next] = 1'b0;
      seg_next          = cur_pattern;
      dp_next           = ~display_dp[idx_next];
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= frame_boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed self-checking bench for seg7_scan_controller with SCAN_DIV=8, BLANK_CYC=2.
// Cycle n means n rising edges since reset was released; frame k starts at cycle 32k.
module tb_seg7_scan_controller;

  logic        in_clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic        pending;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_controller #(
    .DIGITS    (4),
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .in_clk     (in_clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .pending    (pending),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic step();
    @(posedge in_clk);
    #1;
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d);
    load  = ld;
    value = v;
    dp_in = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    lz_blank = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    repeat (3) @(posedge in_clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Reset release and scan timing
    checkOutput("rst_an", an, 4'hF);
    checkOutput("rst_seg", seg, 7'h7F);
    checkOutput("rst_dp", dp, 1'b1);
    checkOutput("rst_pending", pending, 1'b0);
    checkOutput("rst_tick", frame_tick, 1'b0);
    stepTo(1);
    checkOutput("c1_an", an, 4'hF);
    stepTo(2);
    checkOutput("c2_an", an, 4'hE);
    checkOutput("c2_seg", seg, 7'h40);
    stepTo(7);
    checkOutput("c7_an", an, 4'hE);
    stepTo(8);
    checkOutput("c8_an", an, 4'hF);
    checkOutput("c8_seg", seg, 7'h7F);
    stepTo(9);
    checkOutput("c9_an", an, 4'hF);
    stepTo(10);
    checkOutput("c10_an", an, 4'hD);
    stepTo(31);
    checkOutput("c31_tick", frame_tick, 1'b0);
    checkOutput("c31_an", an, 4'h7);
    stepTo(32);
    checkOutput("c32_tick", frame_tick, 1'b1);
    checkOutput("c32_an", an, 4'hF);
    stepTo(33);
    checkOutput("c33_tick", frame_tick, 1'b0);

    // Load 12AF with dp on digit 2
    applyStimulus(1'b1, 16'h12AF, 4'b0100);
    step();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    checkOutput("ld_pending", pending, 1'b1);
    stepTo(63);
    checkOutput("ld_pending_hold", pending, 1'b1);
    stepTo(64);
    checkOutput("ld_tick", frame_tick, 1'b1);
    checkOutput("ld_commit_pending", pending, 1'b0);
    stepTo(66);
    checkOutput("ld_d0_an", an, 4'hE);
    checkOutput("ld_d0_seg", seg, 7'h0E);
    checkOutput("ld_d0_dp", dp, 1'b1);
    stepTo(74);
    checkOutput("ld_d1_an", an, 4'hD);
    checkOutput("ld_d1_seg", seg, 7'h08);
    stepTo(82);
    checkOutput("ld_d2_an", an, 4'hB);
    checkOutput("ld_d2_seg", seg, 7'h24);
    checkOutput("ld_d2_dp", dp, 1'b0);
    stepTo(90);
    checkOutput("ld_d3_an", an, 4'h7);
    checkOutput("ld_d3_seg", seg, 7'h79);
    checkOutput("ld_d3_dp", dp, 1'b1);

    // Leading-zero blanking with 0030
    stepTo(91);
    lz_blank = 1'b1;
    applyStimulus(1'b1, 16'h0030, 4'b0000);
    step();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    stepTo(98);
    checkOutput("lz_d0_seg", seg, 7'h40);
    stepTo(106);
    checkOutput("lz_d1_seg", seg, 7'h30);
    stepTo(114);
    checkOutput("lz_d2_an", an, 4'hB);
    checkOutput("lz_d2_seg", seg, 7'h7F);
    stepTo(122);
    checkOutput("lz_d3_an", an, 4'h7);
    checkOutput("lz_d3_seg", seg, 7'h7F);
    stepTo(123);
    lz_blank = 1'b0;
    step();
    checkOutput("nolz_d3_seg", seg, 7'h40);

    // Collision: second load lands on the frame edge
    stepTo(125);
    applyStimulus(1'b1, 16'h1111, 4'b0000);
    step();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    stepTo(127);
    applyStimulus(1'b1, 16'h2222, 4'b0000);
    step();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    checkOutput("col_tick", frame_tick, 1'b1);
    checkOutput("col_pending", pending, 1'b1);
    stepTo(130);
    checkOutput("col_f1_d0_seg", seg, 7'h79);
    stepTo(154);
    checkOutput("col_f1_d3_seg", seg, 7'h79);
    checkOutput("col_f1_pending", pending, 1'b1);
    stepTo(160);
    checkOutput("col_f2_pending", pending, 1'b0);
    stepTo(162);
    checkOutput("col_f2_d0_seg", seg, 7'h24);
    stepTo(186);
    checkOutput("col_f2_d3_seg", seg, 7'h24);

    // Overwrite: 0005 then 0009 in one frame
    stepTo(187);
    applyStimulus(1'b1, 16'h0005, 4'b0000);
    step();
    applyStimulus(1'b1, 16'h0009, 4'b0000);
    step();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    stepTo(194);
    checkOutput("ovw_d0_seg", seg, 7'h10);
    checkOutput("ovw_pending", pending, 1'b0);

    // Reset during DRIVE(idx=2) with data pending
    stepTo(195);
    applyStimulus(1'b1, 16'h4444, 4'b1111);
    step();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    stepTo(212);
    checkOutput("pre_rst_an", an, 4'hB);
    checkOutput("pre_rst_pending", pending, 1'b1);
    reset = 1'b1;
    step();
    checkOutput("mid_rst_an", an, 4'hF);
    checkOutput("mid_rst_seg", seg, 7'h7F);
    checkOutput("mid_rst_dp", dp, 1'b1);
    checkOutput("mid_rst_pending", pending, 1'b0);
    checkOutput("mid_rst_tick", frame_tick, 1'b0);
    reset = 1'b0;
    cyc   = 0;
    stepTo(1);
    checkOutput("rst2_c1_an", an, 4'hF);
    stepTo(2);
    checkOutput("rst2_c2_an", an, 4'hE);
    checkOutput("rst2_c2_seg", seg, 7'h40);
    stepTo(32);
    checkOutput("rst2_tick", frame_tick, 1'b1);
    checkOutput("rst2_pending", pending, 1'b0);
    stepTo(34);
    checkOutput("rst2_d0_seg", seg, 7'h40);
    checkOutput("rst2_d0_dp", dp, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
